// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared definitions for the neuron-memory update sequencer and its
//   neighbours (clock_gating and its benches).
//   - PH_* : encoding of the externally visible phase output
//   - DEFAULT_DEPTH / DEFAULT_CALC_CYCLES : default sizing constants
//   - state_e : FSM state type, encoded identically to the phase output
//   - calc_width() : counter width that stays >= 1 for tiny counts
`timescale 1ns/1ps
package mem_ctrl_pkg;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_READ  = 2'd1;
  localparam logic [1:0] PH_CALC  = 2'd2;
  localparam logic [1:0] PH_WRITE = 2'd3;

  localparam int DEFAULT_DEPTH       = 1024;
  localparam int DEFAULT_CALC_CYCLES = 100;

  // State encoding equals the phase encoding so phase can be driven
  // straight from the state register.
  typedef enum logic [1:0] {
    ST_IDLE  = PH_IDLE,
    ST_READ  = PH_READ,
    ST_CALC  = PH_CALC,
    ST_WRITE = PH_WRITE
  } state_e;

  function automatic int calc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// phase_counter
//   Up-counter with enable, synchronous clear and terminal-count flag.
//   Ports:
//     clk       in   system clock
//     reset     in   asynchronous active-high reset (count -> 0)
//     i_en      in   increment when high
//     i_clr     in   synchronous clear, wins over i_en
//     o_count   out  current count
//     o_tc      out  high while o_count == MAX_COUNT
`timescale 1ns/1ps
module phase_counter #(
  parameter int WIDTH     = 10,
  parameter int MAX_COUNT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == TC_VAL);

endmodule

// File: rtl/mem_phase_controller.sv
// mem_phase_controller
//   Sequences a neuron-memory update: DEPTH-word read phase, CALC_CYCLES
//   compute phase with both enables low, DEPTH-word write phase. Drives the
//   en_r / en_w inputs of clock_gating from registers so they only change
//   on posedge clk.
//   Ports:
//     clk    in   ungated system clock
//     reset  in   asynchronous active-high reset
//     start  in   request a cycle (only looked at in IDLE)
//     stall  in   memory not ready; drops the phase enable next cycle
//     en_r   out  read clock enable
//     en_w   out  write clock enable
//     addr   out  shared memory address
//     phase  out  0=IDLE 1=READ 2=CALC 3=WRITE
//     busy   out  phase != IDLE
//     done   out  one-cycle pulse after the last write word
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | waiting for start, all outputs low
//   ST_READ  | presenting read addresses, en_r high unless stalled
//   ST_CALC  | compute window, both gated clocks stopped
//   ST_WRITE | presenting write addresses, en_w high unless stalled
`timescale 1ns/1ps
module mem_phase_controller
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int CALC_CYCLES  = DEFAULT_CALC_CYCLES,
  parameter int AUTO_RESTART = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              en_r,
  output logic              en_w,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        phase,
  output logic              busy,
  output logic              done
);

  localparam int CALC_W = calc_width(CALC_CYCLES);

  state_e r_state;
  logic   r_en_r;
  logic   r_en_w;
  logic   r_busy;
  logic   r_done;

  logic              w_xfer;
  logic              w_in_calc;
  logic              w_addr_tc;
  logic              w_calc_tc;
  logic [CALC_W-1:0] w_calc_count;

  // A word is consumed only in a cycle whose enable is high. A stall seen
  // at the end of that cycle just suppresses the next enable, so the
  // address sits on the following word until the enable returns.
  assign w_xfer    = ((r_state == ST_READ)  && r_en_r) ||
                     ((r_state == ST_WRITE) && r_en_w);
  assign w_in_calc = (r_state == ST_CALC);

  phase_counter #(
    .WIDTH     (ADDR_W),
    .MAX_COUNT (DEPTH - 1)
  ) u_addr_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_xfer && !w_addr_tc),
    .i_clr   (w_xfer && w_addr_tc),
    .o_count (addr),
    .o_tc    (w_addr_tc)
  );

  phase_counter #(
    .WIDTH     (CALC_W),
    .MAX_COUNT (CALC_CYCLES - 1)
  ) u_calc_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_in_calc && !w_calc_tc),
    .i_clr   (w_in_calc && w_calc_tc),
    .o_count (w_calc_count),
    .o_tc    (w_calc_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_en_r  <= 1'b0;
      r_en_w  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_READ;
            r_en_r  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_READ: begin
          if (r_en_r && w_addr_tc) begin
            r_state <= ST_CALC;
            r_en_r  <= 1'b0;
          end else begin
            r_en_r <= !stall;
          end
        end
        ST_CALC: begin
          if (w_calc_tc) begin
            r_state <= ST_WRITE;
            r_en_w  <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (r_en_w && w_addr_tc) begin
            r_en_w <= 1'b0;
            r_done <= 1'b1;
            if (AUTO_RESTART != 0) begin
              r_state <= ST_READ;
              r_en_r  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_en_w <= !stall;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_en_r  <= 1'b0;
          r_en_w  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign phase = r_state;
  assign en_r  = r_en_r;
  assign en_w  = r_en_w;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
